// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter between the in-order WB stage and a
// long-latency unit (LU), with a per-register busy scoreboard for decode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pipe_wb_en/pipe_rd/pipe_data  WB write request (always wins)
//   lu_issue/lu_issue_rd          LU op issue; lu_issue_rdy = room left
//   lu_valid/lu_rd/lu_data        LU result; lu_ready = accepted this cycle
//   dec_rs1/dec_rs2/dec_rd        decode indices; dec_stall = hazard
//   pipe_hold                     ask front end for one WB bubble
//   rf_wb_en/rf_rd/rf_wb_data     registered register-file write
module rf_wb_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  output logic        lu_issue_rdy,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic        pipe_hold,
  output logic        rf_wb_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wb_data
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [31:0]   busy;
  logic [31:0]   busy_set;
  logic [31:0]   busy_clr;
  logic [31:0]   busy_next;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_next;
  logic          issue;
  logic          accept;

  assign lu_issue_rdy = count < CMAX;
  assign issue        = lu_issue & lu_issue_rdy;
  // Gated by rst so a result is never reported taken while it is dropped.
  assign accept       = lu_valid & ~pipe_wb_en & ~rst;
  assign lu_ready     = accept;

  assign dec_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

  // Set is applied after clear so a same-cycle re-issue stays busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue)
      busy_set[lu_issue_rd] = 1'b1;
    if (accept)
      busy_clr[lu_rd] = 1'b1;
    busy_next    = (busy & ~busy_clr) | busy_set;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = starve;
    if (!lu_valid || accept)
      starve_next = '0;
    else if (starve < SLIM)
      starve_next = starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      count      <= '0;
      starve     <= '0;
      pipe_hold  <= 1'b0;
      rf_wb_en   <= 1'b0;
      rf_rd      <= '0;
      rf_wb_data <= '0;
    end else begin
      busy      <= busy_next;
      starve    <= starve_next;
      // Looks at the next starve value so hold lines up with the limit.
      pipe_hold <= starve_next >= SLIM;
      if (issue && !accept)
        count <= count + 1'b1;
      else if (accept && !issue && count != '0)
        count <= count - 1'b1;
      if (pipe_wb_en) begin
        rf_wb_en   <= pipe_rd != 5'd0;
        rf_rd      <= pipe_rd;
        rf_wb_data <= pipe_data;
      end else if (lu_valid) begin
        rf_wb_en   <= lu_rd != 5'd0;
        rf_rd      <= lu_rd;
        rf_wb_data <= lu_data;
      end else begin
        rf_wb_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: vector table plus corner sequences.
module tb_rf_wb_scheduler;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_issue_rdy;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        pipe_hold;
  logic        rf_wb_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wb_data;

  int n_vec = 0;
  int n_err = 0;

  rf_wb_scheduler #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_issue_rdy(lu_issue_rdy),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_stall(dec_stall), .pipe_hold(pipe_hold),
    .rf_wb_en(rf_wb_en), .rf_rd(rf_rd), .rf_wb_data(rf_wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        iss;
    logic [4:0]  ird;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  drd;
    logic        e_rdy;
    logic        e_stall;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wb_en = 0; pipe_rd = 0; pipe_data = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic issue1(logic [4:0] r);
    idle();
    lu_issue = 1; lu_issue_rd = r;
    cyc();
  endtask

  initial begin
    idle();
    rst = 1;

    // Vector table: inputs, then pre-edge lu_ready/dec_stall,
    // then post-edge rf_wb_en/rf_rd/rf_wb_data.
    tbl[0]  = '{1,5,32'hDEADBEEF, 0,0, 0,0,0, 0,0,0, 0,0, 1,5,32'hDEADBEEF};
    tbl[1]  = '{1,0,32'h1234, 0,0, 0,0,0, 0,0,0, 0,0, 0,0,32'h1234};
    tbl[2]  = '{0,0,0, 1,7, 0,0,0, 0,0,0, 0,0, 0,0,32'h1234};
    tbl[3]  = '{0,0,0, 0,0, 0,0,0, 0,7,0, 0,1, 0,0,32'h1234};
    tbl[4]  = '{0,0,0, 0,0, 1,7,32'h12, 0,7,0, 1,1, 1,7,32'h12};
    tbl[5]  = '{0,0,0, 0,0, 0,0,0, 0,7,0, 0,0, 0,7,32'h12};
    tbl[6]  = '{1,3,32'hA5, 1,9, 0,0,0, 0,0,0, 0,0, 1,3,32'hA5};
    tbl[7]  = '{0,0,0, 0,0, 0,0,0, 0,0,9, 0,1, 0,3,32'hA5};
    tbl[8]  = '{1,4,32'h44, 0,0, 1,9,32'h99, 9,0,0, 0,1, 1,4,32'h44};
    tbl[9]  = '{0,0,0, 0,0, 1,9,32'h99, 9,0,0, 1,1, 1,9,32'h99};
    tbl[10] = '{0,0,0, 0,0, 0,0,0, 9,0,0, 0,0, 0,9,32'h99};
    tbl[11] = '{0,0,0, 1,0, 0,0,0, 0,0,0, 0,0, 0,9,32'h99};
    tbl[12] = '{0,0,0, 0,0, 1,0,32'h55, 0,0,0, 1,0, 0,0,32'h55};

    // T1: reset with every input active
    pipe_wb_en = 1; pipe_rd = 5; pipe_data = 32'hFFFF_FFFF;
    lu_issue = 1; lu_issue_rd = 7;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h1;
    dec_rs1 = 7; dec_rs2 = 7; dec_rd = 7;
    cyc();
    cyc();
    chk("rst rf_wb_en", 32'(rf_wb_en), 0);
    chk("rst rf_rd", 32'(rf_rd), 0);
    chk("rst rf_wb_data", rf_wb_data, 0);
    chk("rst lu_ready", 32'(lu_ready), 0);
    chk("rst pipe_hold", 32'(pipe_hold), 0);
    chk("rst dec_stall", 32'(dec_stall), 0);
    idle();
    dec_rs1 = 7;
    rst = 0;
    cyc();
    chk("post-rst issue_rdy", 32'(lu_issue_rdy), 1);
    chk("post-rst busy7", 32'(dec_stall), 0);

    // T2/T3 and mixed traffic from the table
    for (int i = 0; i < 13; i++) begin
      pipe_wb_en = tbl[i].wb; pipe_rd = tbl[i].wrd;
      pipe_data = tbl[i].wdat;
      lu_issue = tbl[i].iss; lu_issue_rd = tbl[i].ird;
      lu_valid = tbl[i].lv; lu_rd = tbl[i].lrd; lu_data = tbl[i].ldat;
      dec_rs1 = tbl[i].rs1; dec_rs2 = tbl[i].rs2; dec_rd = tbl[i].drd;
      #1;
      chk($sformatf("v%0d lu_ready", i), 32'(lu_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d dec_stall", i), 32'(dec_stall), 32'(tbl[i].e_stall));
      cyc();
      chk($sformatf("v%0d rf_wb_en", i), 32'(rf_wb_en), 32'(tbl[i].e_en));
      chk($sformatf("v%0d rf_rd", i), 32'(rf_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d rf_wb_data", i), rf_wb_data, tbl[i].e_dat);
    end
    idle();

    // T4: WB and LU collide; LU starves until pipe_hold
    issue1(2);
    idle();
    for (int k = 1; k <= 10; k++) begin
      pipe_wb_en = 1; pipe_rd = 1; pipe_data = 32'h100 + k;
      lu_valid = 1; lu_rd = 2; lu_data = 32'hCAFE;
      #1;
      chk($sformatf("t4 c%0d lu_ready", k), 32'(lu_ready), 0);
      chk($sformatf("t4 c%0d pipe_hold", k), 32'(pipe_hold),
          32'(k >= LIM + 1));
      cyc();
    end
    pipe_wb_en = 0;
    #1;
    chk("t4 release lu_ready", 32'(lu_ready), 1);
    chk("t4 release hold", 32'(pipe_hold), 1);
    cyc();
    chk("t4 commit en", 32'(rf_wb_en), 1);
    chk("t4 commit rd", 32'(rf_rd), 2);
    chk("t4 commit data", rf_wb_data, 32'hCAFE);
    chk("t4 hold drop", 32'(pipe_hold), 0);
    idle();
    cyc();

    // T5: capacity
    issue1(1);
    issue1(2);
    issue1(3);
    chk("t5 rdy at 3", 32'(lu_issue_rdy), 1);
    issue1(4);
    chk("t5 rdy at 4", 32'(lu_issue_rdy), 0);
    issue1(5);
    idle();
    dec_rs1 = 5;
    #1;
    chk("t5 5th ignored", 32'(dec_stall), 0);
    chk("t5 still full", 32'(lu_issue_rdy), 0);
    // accept while full: concurrent issue is refused
    idle();
    lu_valid = 1; lu_rd = 1; lu_data = 32'h11;
    lu_issue = 1; lu_issue_rd = 6;
    cyc();
    idle();
    dec_rs1 = 6; dec_rs2 = 1;
    #1;
    chk("t5 refused/cleared", 32'(dec_stall), 0);
    chk("t5 rdy at 3b", 32'(lu_issue_rdy), 1);
    // accept plus issue together: count unchanged
    idle();
    lu_valid = 1; lu_rd = 2; lu_data = 32'h22;
    lu_issue = 1; lu_issue_rd = 7;
    cyc();
    idle();
    dec_rd = 7;
    #1;
    chk("t5 busy7 set", 32'(dec_stall), 1);
    chk("t5 count kept", 32'(lu_issue_rdy), 1);
    issue1(8);
    chk("t5 full again", 32'(lu_issue_rdy), 0);

    // T6: reset with outstanding ops and a stall in progress
    idle();
    dec_rs1 = 3;
    #1;
    chk("t6 pre stall", 32'(dec_stall), 1);
    rst = 1;
    lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
    #1;
    chk("t6 rst lu_ready", 32'(lu_ready), 0);
    cyc();
    rst = 0;
    idle();
    dec_rs1 = 4; dec_rs2 = 7; dec_rd = 8;
    #1;
    chk("t6 busy cleared", 32'(dec_stall), 0);
    chk("t6 lu_ready", 32'(lu_ready), 0);
    chk("t6 rdy", 32'(lu_issue_rdy), 1);
    issue1(10);
    issue1(11);
    issue1(12);
    chk("t6 count from 0", 32'(lu_issue_rdy), 1);
    issue1(13);
    chk("t6 full at 4", 32'(lu_issue_rdy), 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
